// File: rtl/cordic_pkg.sv
// Shared constants, types and helpers for the folded CORDIC engine.
// The arctangent table is Q2.30 and is rounded to the working fraction at elaboration.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // Iteration counter width: covers N_ITER up to 16.
    localparam int ITER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // round(atan(2^-i) * 2^30), i = 0..15
    localparam logic signed [31:0] ATAN_TABLE [16] = '{
        32'sd843314857, 32'sd497837829, 32'sd263043837, 32'sd133525159,
        32'sd67021687,  32'sd33543516,  32'sd16775851,  32'sd8388437,
        32'sd4194283,   32'sd2097149,   32'sd1048576,   32'sd524288,
        32'sd262144,    32'sd131072,    32'sd65536,     32'sd32768
    };

    // Round the Q2.30 entry to `frac` fraction bits (round half up).
    function automatic logic signed [31:0] atan_round(input int idx, input int frac);
        logic signed [32:0] t;
        t = 33'(ATAN_TABLE[idx]);
        if (frac < 30) begin
            t = t + (33'sd1 <<< (29 - frac));
        end
        return 32'(t >>> (30 - frac));
    endfunction

    // Clamp a signed value to the w-bit two's complement range.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_iter_if.sv
// Operand/result stream bundle for the CORDIC engine: valid/ready on both sides.
// master = the caller that supplies operands and consumes results; slave = the engine.
interface cordic_iter_if #(
    parameter int W = 12
);

    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] z_in;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;
    logic signed [W-1:0] z_out;

    modport master (
        output in_valid, mode, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out
    );

    modport slave (
        input  in_valid, mode, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out
    );

endinterface

// File: rtl/cordic_iter_dp.sv
// Combinational micro-rotation: two variable arithmetic shifters, direction
// decision and the x/y/z add/subtract for iteration i.
module cordic_iter_dp
    import cordic_pkg::*;
#(
    parameter int IW = 14
) (
    input  logic signed [IW-1:0]     x_i,
    input  logic signed [IW-1:0]     y_i,
    input  logic signed [IW-1:0]     z_i,
    input  logic        [ITER_W-1:0] i_i,
    input  logic                     mode_i,
    input  logic signed [IW-1:0]     atan_i,
    output logic signed [IW-1:0]     x_o,
    output logic signed [IW-1:0]     y_o,
    output logic signed [IW-1:0]     z_o
);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;
    logic                 d_pos;

    always_comb begin
        x_sh = x_i >>> i_i;
        y_sh = y_i >>> i_i;
        // Vectoring steers y toward zero, rotation steers z toward zero.
        d_pos = (mode_i == MODE_VEC) ? y_i[IW-1] : ~z_i[IW-1];

        if (d_pos) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end
    end

endmodule

// File: rtl/cordic_iter.sv
// Folded CORDIC engine: accepts one operand, runs N_ITER micro-rotations on a
// shared datapath, then holds the saturated result until the consumer takes it.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int W      = 12,
    parameter int FRAC   = 10,
    parameter int N_ITER = 11,
    parameter int G      = 2
) (
    input logic          clock,
    input logic          reset,
    cordic_iter_if.slave bus
);

    localparam int                IW     = W + G;
    localparam logic [ITER_W-1:0] LAST_I = ITER_W'(N_ITER - 1);

    state_e               state_q, state_d;
    logic [ITER_W-1:0]    i_q, i_d;
    logic                 mode_q, mode_d;
    logic signed [IW-1:0] x_q, x_d;
    logic signed [IW-1:0] y_q, y_d;
    logic signed [IW-1:0] z_q, z_d;
    logic signed [W-1:0]  xo_q, xo_d;
    logic signed [W-1:0]  yo_q, yo_d;
    logic signed [W-1:0]  zo_q, zo_d;

    logic signed [IW-1:0] atan_cur;
    logic signed [IW-1:0] dp_x, dp_y, dp_z;
    logic                 accept;
    logic                 last_step;

    assign accept    = (state_q == ST_IDLE) && bus.in_valid;
    assign last_step = (state_q == ST_RUN) && (i_q == LAST_I);

    // Constant-folded angle selection; every candidate is an elaboration-time value.
    always_comb begin
        atan_cur = '0;
        for (int k = 0; k < N_ITER; k++) begin
            if (i_q == ITER_W'(k)) begin
                atan_cur = IW'(atan_round(k, FRAC));
            end
        end
    end

    cordic_iter_dp #(
        .IW (IW)
    ) u_dp (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .i_i    (i_q),
        .mode_i (mode_q),
        .atan_i (atan_cur),
        .x_o    (dp_x),
        .y_o    (dp_y),
        .z_o    (dp_z)
    );

    // FSM: state register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        // NOTE: default first, so no path leaves state_d unassigned and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_RUN;
            ST_RUN:  if (i_q == LAST_I) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
    end

    assign bus.x_out = xo_q;
    assign bus.y_out = yo_q;
    assign bus.z_out = zo_q;

    // Datapath next-state: load on accept, iterate in RUN, capture on the last step.
    always_comb begin
        i_d    = i_q;
        mode_d = mode_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        xo_d   = xo_q;
        yo_d   = yo_q;
        zo_d   = zo_q;

        if (accept) begin
            i_d    = '0;
            mode_d = bus.mode;
            x_d    = IW'(bus.x_in);
            y_d    = IW'(bus.y_in);
            z_d    = IW'(bus.z_in);
        end else if (state_q == ST_RUN) begin
            i_d = i_q + ITER_W'(1);
            x_d = dp_x;
            y_d = dp_y;
            z_d = dp_z;
            if (last_step) begin
                xo_d = W'(sat_w(64'(dp_x), W));
                yo_d = W'(sat_w(64'(dp_y), W));
                zo_d = W'(sat_w(64'(dp_z), W));
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: working registers are cleared too, so an aborted operation leaves nothing behind.
        if (reset) begin
            i_q    <= '0;
            mode_q <= MODE_ROT;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            xo_q   <= '0;
            yo_q   <= '0;
            zo_q   <= '0;
        end else begin
            i_q    <= i_d;
            mode_q <= mode_d;
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            xo_q   <= xo_d;
            yo_q   <= yo_d;
            zo_q   <= zo_d;
        end
    end

endmodule

// File: tb/tb_cordic_iter.sv
// Self-checking bench for cordic_iter: table-driven vectors through a scoreboard,
// plus backpressure and mid-run reset sequences.
module tb_cordic_iter;
    import cordic_pkg::*;

    localparam int W      = 12;
    localparam int FRAC   = 10;
    localparam int N_ITER = 11;
    localparam int G      = 2;
    localparam int IW     = W + G;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    cordic_iter_if #(.W(W)) bus ();

    cordic_iter #(
        .W      (W),
        .FRAC   (FRAC),
        .N_ITER (N_ITER),
        .G      (G)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string    name;
        logic     m;
        int       x, y, z;
        bit [2:0] ana_en;   // {x, y, z} analytic checks enabled
        int       ax, ay, az;
        int       tol;
    } vec_t;

    typedef struct {
        string    name;
        int       ex, ey, ez;
        bit [2:0] ana_en;
        int       ax, ay, az;
        int       tol;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_near(input string name, input int act, input int req, input int tol);
        total++;
        if (act > req + tol || act < req - tol) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d +/-%0d", name, act, req, tol);
        end
    endtask

    function automatic int wrap_iw(input int v);
        logic signed [IW-1:0] t;
        t = v[IW-1:0];
        return int'(t);
    endfunction

    function automatic int sat_out(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int atan_fix(input int i);
        real    a;
        longint q30;
        a   = $atan(1.0 / (2.0 ** i)) * 1073741824.0;
        q30 = longint'(a);
        return int'((q30 + 64'sd524288) >>> 20);
    endfunction

    // Bit-accurate reference of the recurrence on W+G-bit values.
    task automatic model(input logic m, input int xi, input int yi, input int zi,
                         output int xo, output int yo, output int zo);
        int x, y, z, xn, yn;
        bit dpos;
        x = xi;
        y = yi;
        z = zi;
        for (int i = 0; i < N_ITER; i++) begin
            dpos = (m == MODE_ROT) ? (z >= 0) : (y < 0);
            if (dpos) begin
                xn = x - (y >>> i);
                yn = y + (x >>> i);
                z  = wrap_iw(z - atan_fix(i));
            end else begin
                xn = x + (y >>> i);
                yn = y - (x >>> i);
                z  = wrap_iw(z + atan_fix(i));
            end
            x = wrap_iw(xn);
            y = wrap_iw(yn);
        end
        xo = sat_out(x);
        yo = sat_out(y);
        zo = sat_out(z);
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.name   = v.name;
        e.ana_en = v.ana_en;
        e.ax     = v.ax;
        e.ay     = v.ay;
        e.az     = v.az;
        e.tol    = v.tol;
        model(v.m, v.x, v.y, v.z, e.ex, e.ey, e.ez);
        sb.push_back(e);
    endtask

    // Drive one operand, wait for the accepting edge, record it in the scoreboard.
    task automatic send(input vec_t v, output int acc_cyc);
        int n;
        bus.mode     = v.m;
        bus.x_in     = W'(v.x);
        bus.y_in     = W'(v.y);
        bus.z_in     = W'(v.z);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL %s/accept: in_ready still 0 after %0d cycles, expected 1", v.name, n);
        end
        @(posedge clock);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        push_exp(v);
    endtask

    // Wait for a result, compare against the scoreboard head, optionally release it.
    task automatic collect(input int acc_cyc, input bit release_now);
        exp_t e;
        int   n;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check({e.name, "/latency"}, cyc - acc_cyc, N_ITER);
        check({e.name, "/x_exact"}, int'(bus.x_out), e.ex);
        check({e.name, "/y_exact"}, int'(bus.y_out), e.ey);
        check({e.name, "/z_exact"}, int'(bus.z_out), e.ez);
        if (e.ana_en[2]) check_near({e.name, "/x_ref"}, int'(bus.x_out), e.ax, e.tol);
        if (e.ana_en[1]) check_near({e.name, "/y_ref"}, int'(bus.y_out), e.ay, e.tol);
        if (e.ana_en[0]) check_near({e.name, "/z_ref"}, int'(bus.z_out), e.az, e.tol);
        if (release_now) begin
            bus.out_ready = 1'b1;
            @(posedge clock);
            #1;
            check({e.name, "/release_valid"}, int'(bus.out_valid), 0);
            check({e.name, "/release_ready"}, int'(bus.in_ready), 1);
        end
    endtask

    vec_t vecs[$];
    vec_t va, vb, vc, vd;
    int   acc, prev_acc, ex, ey, ez, n;

    initial begin
        bus.in_valid  = 1'b0;
        bus.mode      = MODE_ROT;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.z_in      = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("reset/out_valid", int'(bus.out_valid), 0);
        check("reset/in_ready", int'(bus.in_ready), 1);
        check("reset/x_out", int'(bus.x_out), 0);
        check("reset/y_out", int'(bus.y_out), 0);
        check("reset/z_out", int'(bus.z_out), 0);

        vecs.push_back('{"rot_pi6",     MODE_ROT, 622, 0, 536,     3'b111, 887, 512, 0,    4});
        vecs.push_back('{"rot_mpi2",    MODE_ROT, 622, 0, -1608,   3'b110, 0, -1024, 0,    4});
        vecs.push_back('{"vec_45",      MODE_VEC, 512, 512, 0,     3'b111, 1192, 0, 804,   4});
        vecs.push_back('{"vec_sat",     MODE_VEC, 1536, 1536, 0,   3'b101, 2047, 0, 804,   4});
        vecs.push_back('{"rot_pi4",     MODE_ROT, 622, 0, 804,     3'b111, 724, 724, 0,    6});
        vecs.push_back('{"vec_negy",    MODE_VEC, 1000, -300, 0,   3'b111, 1719, 0, -298,  6});
        vecs.push_back('{"rot_y_mpi6",  MODE_ROT, 0, 622, -536,    3'b111, 512, 887, 0,    6});
        for (int k = 0; k < 5; k++) begin
            vecs.push_back('{$sformatf("rot_rand%0d", k), MODE_ROT,
                             int'($urandom_range(1200)) - 600, int'($urandom_range(1200)) - 600,
                             int'($urandom_range(3200)) - 1600, 3'b000, 0, 0, 0, 0});
        end

        // Back-to-back with out_ready high: one accept every N_ITER+2 clocks.
        prev_acc = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            send(vecs[k], acc);
            if (k > 0) check({vecs[k].name, "/throughput"}, acc - prev_acc, N_ITER + 2);
            prev_acc = acc;
            collect(acc, 1'b1);
        end

        // Backpressure: result held, new operand ignored until DONE exits.
        va = '{"bp_a", MODE_ROT, 622, 0, 536,   3'b000, 0, 0, 0, 0};
        vb = '{"bp_b", MODE_VEC, 700, -200, 0,  3'b000, 0, 0, 0, 0};
        model(va.m, va.x, va.y, va.z, ex, ey, ez);
        bus.out_ready = 1'b0;
        send(va, acc);
        collect(acc, 1'b0);
        bus.mode     = vb.m;
        bus.x_in     = W'(vb.x);
        bus.y_in     = W'(vb.y);
        bus.z_in     = W'(vb.z);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            check("bp/out_valid", int'(bus.out_valid), 1);
            check("bp/in_ready", int'(bus.in_ready), 0);
            check("bp/x_hold", int'(bus.x_out), ex);
            check("bp/y_hold", int'(bus.y_out), ey);
            check("bp/z_hold", int'(bus.z_out), ez);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp/exit_valid", int'(bus.out_valid), 0);
        check("bp/exit_ready", int'(bus.in_ready), 1);
        @(posedge clock);
        #1;
        acc = cyc;
        check("bp/next_taken", int'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        push_exp(vb);
        collect(acc, 1'b1);

        // Reset during RUN step 5: operation discarded, fresh one completes normally.
        vc = '{"rst_abort", MODE_ROT, 622, 0, 804,   3'b000, 0, 0, 0, 0};
        vd = '{"rst_fresh", MODE_ROT, 622, 0, 536,   3'b111, 887, 512, 0, 4};
        send(vc, acc);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        check("rst/out_valid", int'(bus.out_valid), 0);
        check("rst/in_ready", int'(bus.in_ready), 1);
        check("rst/x_out", int'(bus.x_out), 0);
        check("rst/y_out", int'(bus.y_out), 0);
        check("rst/z_out", int'(bus.z_out), 0);
        n = 0;
        repeat (15) begin
            @(posedge clock);
            #1;
            if (bus.out_valid) n++;
        end
        check("rst/no_stale_result", n, 0);
        send(vd, acc);
        collect(acc, 1'b1);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_iter.md
Name: cordic_iter

Overview:
- Folded (iterative) CORDIC engine: one micro-rotation per clock on a single shared datapath, replacing a chain of fixed-step pipeline stages.
- Parametrised in width, fraction bits and iteration count.
- Supports rotation mode (sin/cos, vector rotate) and vectoring mode (magnitude/atan2).
- Valid/ready handshakes on both sides, so it drops into any stream in the processor.

Parameters:
- W, 12, signed width of x/y/z ports; format Q(W-FRAC).FRAC
- FRAC, 10, fraction bits; range 1..30, FRAC <= W-2
- N_ITER, 11, micro-rotations per operation; range 1..16
- G, 2, guard bits added to internal x/y/z registers (internal width W+G)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  engine can accept an operand (high only in IDLE)
- mode  in  1  0 = rotation, 1 = vectoring; sampled on accept
- x_in  in  W  signed x operand
- y_in  in  W  signed y operand
- z_in  in  W  signed angle operand, radians, same Q format
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- x_out  out  W  signed result x, saturated
- y_out  out  W  signed result y, saturated
- z_out  out  W  signed residual/accumulated angle, saturated

Behaviour:
- Clocking and reset: one clock. reset is synchronous, active-high and overrides everything, including mid-operation. On reset:
  - state goes to IDLE, iteration counter i = 0
  - x_out, y_out, z_out = 0; out_valid = 0; in_ready = 1 in the cycle after reset deasserts
  - any in-flight operation is discarded with no output.
- State machine:
  - IDLE: in_ready = 1. On in_valid & in_ready, load the internal regs with x_in, y_in, z_in sign-extended to W+G, latch mode, set i = 0, go to RUN.
  - RUN: each clock performs micro-rotation i, then i <= i+1. After step N_ITER-1, go to DONE and register saturated results into x_out/y_out/z_out with out_valid = 1.
  - DONE: out_valid = 1. Outputs are held stable while out_ready = 0. On out_ready = 1, go to IDLE with out_valid = 0.
  - in_ready is 0 in RUN and DONE. No same-cycle accept on result release: the next accept happens no earlier than the cycle after DONE exits.
- Latency: out_valid rises exactly N_ITER clocks after the accepting edge. Throughput is one operation per N_ITER+2 clocks with out_ready held high.
- Micro-rotation i, direction d = +1 or -1:
  - Rotation mode: d = +1 if z >= 0, else -1 (drives z toward 0).
  - Vectoring mode: d = +1 if y < 0, else -1 (drives y toward 0).
  - Updates: x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*atan_i.
  - Shifts are arithmetic on W+G-bit values. Adds wrap at W+G bits; guard bits prevent wrap for in-range inputs.
- atan_i: ATAN_TABLE[i] (Q2.30) rounded to FRAC bits, i.e. add 2^(29-FRAC), then >>> (30-FRAC). Computed at elaboration; there is no runtime ROM.
- Gain: no gain compensation inside the block; x/y results carry K ~= 1.6468 (for N_ITER >= 8). The caller pre-scales by 1/K.
- Output saturation: each W+G-bit value is clamped to [-2^(W-1), 2^(W-1)-1] when registered into the output.
- Input domain:
  - Rotation mode: |z_in| <= pi/2.
  - Vectoring mode: x_in >= 0.
  - Outside the domain, results are defined only by the recurrence above (no error flag).
- The mode bit is ignored except on the accept edge. in_valid is ignored outside IDLE.

Decomposition:
- Package cordic_pkg:
  - ATAN_TABLE[0:15], 32-bit Q2.30 constants, round(atan(2^-i)*2^30)
  - MODE_ROT = 0, MODE_VEC = 1
  - state encoding IDLE/RUN/DONE
  - saturation function sat_w
- Sub-module cordic_iter_dp: combinational datapath. Inputs: x, y, z, i, mode, atan_i. Outputs: next x/y/z. Contains the two variable-shift barrel shifters and the direction logic. cordic_iter holds the FSM, counter, registers and saturation.

Test Plan (W=12, FRAC=10, N_ITER=11, 1.0 = 1024):
- Rotation, x=622 (1/K), y=0, z=536 (pi/6) -> out_valid exactly 11 clocks after accept; x_out = 887 +/-4, y_out = 512 +/-4, z_out = 0 +/-4.
- Rotation, x=622, y=0, z=-1608 (-pi/2) -> x_out = 0 +/-4, y_out = -1024 +/-4.
- Vectoring, x=512, y=512, z=0 -> x_out = 1192 +/-4 (K*724), y_out = 0 +/-4, z_out = 804 +/-4 (pi/4).
- Vectoring saturation, x=1536, y=1536 -> x_out = 2047 (clamped), z_out = 804 +/-4.
- Backpressure: hold out_ready=0 for 5 clocks in DONE with in_valid=1 and a new operand -> outputs unchanged, in_ready=0, new operand not taken; release -> IDLE, then accept on the following cycle.
- Reset at RUN step 5 -> next cycle out_valid=0, outputs 0, in_ready=1; a fresh operation then completes correctly with the 11-clock latency.
